// File: rtl/z80_dbg_master_pkg.sv
// z80_dbg_master_pkg: bus structs, opcodes, FSM states and command helpers for the debug bus master
package z80_dbg_master_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        rdn;
    logic        wrn;
    logic        inta;
  } Z80MasterBus;
  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_IORD = 8'h49;
  localparam logic [7:0] OP_IOWR = 8'h4F;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  typedef enum logic [3:0] {IDLE, ADDR_HI, ADDR_LO, DATA, REQ, SETUP, STROBE, HOLD, RELEASE, RESP, ERR} state_t;
  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;
  function automatic logic op_known(input logic [7:0] op);
    return op == OP_RD || op == OP_WR || op == OP_IORD || op == OP_IOWR;
  endfunction
  function automatic logic op_write(input logic [7:0] op);
    return op == OP_WR || op == OP_IOWR;
  endfunction
  function automatic logic op_io(input logic [7:0] op);
    return op == OP_IORD || op == OP_IOWR;
  endfunction
endpackage

// File: rtl/z80_dbg_master_if.sv
// z80_dbg_master_if: bus-ownership handshake plus Z80 master/slave bus bundle
// master drives busrq_n/active/mreq_n/iorq_n/obus, slave drives busak_n/ibus
interface z80_dbg_master_if;
  import z80_dbg_master_pkg::*;
  logic        busrq_n;
  logic        busak_n;
  logic        active;
  logic        mreq_n;
  logic        iorq_n;
  Z80MasterBus obus;
  Z80SlaveBus  ibus;
  modport master (output busrq_n, active, mreq_n, iorq_n, obus, input busak_n, ibus);
  modport slave (input busrq_n, active, mreq_n, iorq_n, obus, output busak_n, ibus);
endinterface

// File: rtl/z80_dbg_master_cmd_parser.sv
// z80_dbg_master_cmd_parser: assembles rx bytes into a command with inter-byte timeout
// in: clk, rst_n, busy, rx_valid, rx_data; out: cmd, cmd_valid/cmd_err one-cycle pulses
module z80_dbg_master_cmd_parser
  import z80_dbg_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output cmd_t       cmd,
  output logic       cmd_valid,
  output logic       cmd_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [TW-1:0] tcnt;
  logic take;
  // bytes are dropped while a command is pending or being executed
  assign take = rx_valid & ~busy & ~cmd_valid & ~cmd_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      tcnt      <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      tcnt      <= take || state == IDLE ? '0 : tcnt + 1'b1;
      if (take) begin
        case (state)
          IDLE: begin
            cmd.op  <= rx_data;
            state   <= op_known(rx_data) ? ADDR_HI : IDLE;
            cmd_err <= ~op_known(rx_data);
          end
          ADDR_HI: begin
            cmd.addr[15:8] <= rx_data;
            state          <= ADDR_LO;
          end
          ADDR_LO: begin
            cmd.addr[7:0] <= rx_data;
            state         <= op_write(cmd.op) ? DATA : IDLE;
            cmd_valid     <= ~op_write(cmd.op);
          end
          default: begin
            cmd.data  <= rx_data;
            state     <= IDLE;
            cmd_valid <= 1'b1;
          end
        endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: rtl/z80_dbg_master.sv
// z80_dbg_master: UART-driven second Z80 bus master performing single memory/IO cycles
// in: clk, rst_n, rx_valid/rx_data, tx_ready; out: tx_valid/tx_data; bus: z80_dbg_master_if.master
module z80_dbg_master
  import z80_dbg_master_pkg::*;
#(
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  z80_dbg_master_if.master bus
);
  state_t state;
  cmd_t cmd, cur;
  logic cmd_valid, cmd_err, busy;
  logic [3:0] cnt;
  assign busy = state != IDLE;
  z80_dbg_master_cmd_parser #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_parser (
    .clk(clk),
    .rst_n(rst_n),
    .busy(busy),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .cmd_err(cmd_err)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      cnt         <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      bus.busrq_n <= 1'b1;
      bus.active  <= 1'b0;
      bus.mreq_n  <= 1'b1;
      bus.iorq_n  <= 1'b1;
      bus.obus    <= '{16'h0, 8'h0, 1'b1, 1'b1, 1'b1};
    end else begin
      case (state)
        IDLE: begin
          if (cmd_err) begin
            tx_data  <= RSP_ERR;
            tx_valid <= 1'b1;
            state    <= ERR;
          end else if (cmd_valid) begin
            cur         <= cmd;
            bus.busrq_n <= 1'b0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (!bus.busak_n) begin
            state            <= SETUP;
            bus.active       <= 1'b1;
            bus.obus.addr    <= cur.addr;
            bus.obus.dmaster <= cur.data;
            bus.mreq_n       <= op_io(cur.op);
            bus.iorq_n       <= ~op_io(cur.op);
          end
        end
        SETUP: begin
          state         <= STROBE;
          bus.obus.rdn  <= op_write(cur.op);
          bus.obus.wrn  <= ~op_write(cur.op);
          cnt           <= 4'd1;
        end
        STROBE: begin
          // cnt saturates at STROBE_CYCLES; mwait then stretches the strobe
          if (cnt >= 4'(STROBE_CYCLES) && bus.ibus.mwait) begin
            state        <= HOLD;
            bus.obus.rdn <= 1'b1;
            bus.obus.wrn <= 1'b1;
            bus.mreq_n   <= 1'b1;
            bus.iorq_n   <= 1'b1;
            tx_data      <= op_write(cur.op) ? tx_data : bus.ibus.dslave;
          end else if (cnt < 4'(STROBE_CYCLES)) begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          state       <= RELEASE;
          bus.active  <= 1'b0;
          bus.busrq_n <= 1'b1;
        end
        RELEASE: begin
          state    <= RESP;
          tx_valid <= 1'b1;
          tx_data  <= op_write(cur.op) ? RSP_OK : tx_data;
        end
        default: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/z80_dbg_master.md
Name: z80_dbg_master

Overview:
- Second bus master on the Z80 system bus. Takes a byte-command stream from a UART receiver and performs single memory or IO read/write cycles against the existing slaves (ROM, UART, future RAM).
- Before driving the bus it takes the bus from the tv80 core via busrq_n/busak_n. While it holds the bus, its master struct is selected in sysmux through msel, and its mreq_n/iorq_n replace the CPU's at the address decoder.
- Used for program load and memory peek/poke without a CPU-side monitor.

Parameters:
- STROBE_CYCLES, 2, minimum clk cycles rdn/wrn are held low before wait sampling ends the strobe (range 1..15).
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between bytes of one command before it is abandoned.

Ports:
- clk  in  1  system clock (masterclk domain)
- rst_n  in  1  synchronous active-low reset
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received command byte
- tx_valid  out  1  response byte valid; held until accepted
- tx_data  out  8  response byte
- tx_ready  in  1  UART transmitter accepts byte when tx_valid & tx_ready
- busrq_n  out  1  bus request to tv80 busrq_n
- busak_n  in  1  bus acknowledge from tv80
- active  out  1  drives sysmux msel; 1 while bus owned
- mreq_n  out  1  memory request to addr_decoder mux
- iorq_n  out  1  IO request to addr_decoder mux
- obus  out  Z80MasterBus  addr, dmaster, rdn, wrn, inta
- ibus  in  Z80SlaveBus  dslave, mwait (active-low wait)

Behaviour:
- Reset values: tx_valid=0, tx_data=0, busrq_n=1, active=0, mreq_n=1, iorq_n=1. obus.addr=0, obus.dmaster=0, obus.rdn=1, obus.wrn=1, obus.inta=1 (always 1). All state cleared, FSM=IDLE. Reset mid-cycle releases the bus immediately.
- Commands (ASCII opcodes, then binary operands):
  - 'R'(0x52) AH AL: memory read.
  - 'W'(0x57) AH AL D: memory write.
  - 'I'(0x49) AH AL: IO read.
  - 'O'(0x4F) AH AL D: IO write.
- Responses:
  - Reads return the data byte.
  - Writes return 'K'(0x4B).
  - Unknown opcode returns '?'(0x3F), FSM back to IDLE, no bus activity.
- FSM:
  - IDLE: wait for rx_valid, latch opcode → ADDR_HI (or ERR on unknown opcode).
  - ADDR_HI → ADDR_LO → (write ? DATA : REQ). Each step advances on rx_valid.
  - DATA → REQ on rx_valid.
  - REQ: busrq_n=0; advance to SETUP the cycle after busak_n is sampled 0.
  - SETUP (1 cycle): active=1; addr/dmaster driven; mreq_n or iorq_n=0; rdn=wrn=1.
  - STROBE: rdn or wrn=0. Counter runs STROBE_CYCLES cycles. Leave STROBE on the first cycle where counter has expired AND ibus.mwait=1. On that cycle, read commands capture ibus.dslave into the response register.
  - HOLD (1 cycle): strobes=1, mreq_n=iorq_n=1, addr held, active=1.
  - RELEASE: active=0, busrq_n=1 → RESP.
  - RESP/ERR: tx_valid=1 until tx_ready; then IDLE.
- Timeout counter: reset on every rx_valid; counts only in ADDR_HI/ADDR_LO/DATA. Reaching TIMEOUT_CYCLES → IDLE silently, no response.
- rx_valid in any state other than IDLE/ADDR_HI/ADDR_LO/DATA is dropped, with no buffering.
- A bus cycle, once in SETUP, always completes. mwait held low extends STROBE indefinitely; there is no bus timeout.
- Address is {AH,AL}. IO cycles drive the full 16 bits; the decoder uses the low byte.
- active never asserts unless busak_n=0 was observed. busrq_n is not released before strobes are high.

Decomposition:
- Shared package: opcode constants (OP_RD, OP_WR, OP_IORD, OP_IOWR, RSP_OK, RSP_ERR) and the FSM state enum.
- Z80MasterBus/Z80SlaveBus come from the existing Z80Bus header, unchanged.
- One natural sub-module: dbg_cmd_parser (rx byte FSM + timeout, outputs a command struct with a valid pulse). The bus-cycle FSM and response logic stay in the top module.

Test Plan:
- Bytes 52 01 23, slave returns dslave=0xA5, mwait=1, busak_n given 3 cycles after busrq_n → addr=0x0123, mreq_n=0, rdn low exactly 2 cycles, tx_data=0xA5 once, busrq_n=1 afterward.
- Bytes 57 80 00 3C → addr=0x8000, dmaster=0x3C, wrn low 2 cycles, iorq_n stays 1, response 0x4B.
- Bytes 4F 00 10 55 with mwait=0 for 5 cycles → iorq_n=0, wrn low 7 cycles, response 0x4B.
- Byte 0x41 → response 0x3F, busrq_n never asserts. Then 'R' 00 00 completes normally.
- Bytes 52 12, then no byte for TIMEOUT_CYCLES (bench sets it to 50) → silent return to IDLE; next 49 00 07 performs an IO read at 0x0007.
- rst_n=0 asserted during STROBE → next cycle rdn=1, mreq_n=1, active=0, busrq_n=1, tx_valid=0.
